// File: rtl/up_dn_seek_ctrl_pkg.sv
// Shared types and constants for the up/down counter seek controller.
// No timing or flow control of its own; consumed by the interface, timer and FSM.
package up_dn_ctrl_pkg;

  localparam int CTR_W_DEF = 5;
  localparam int GAP_W     = 4;

  localparam logic MODE_SEEK = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    SETTLE,
    DONE
  } state_t;

endpackage

// File: rtl/up_dn_seek_ctrl_if.sv
// Request and counter-side signal bundle; slave = controller, master = driver/counter side.
// Request uses valid/ready; counter strobes are single-cycle with no backpressure.
interface up_dn_seek_ctrl_if
  import up_dn_ctrl_pkg::*;
#(
  parameter int W = CTR_W_DEF
);

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_target;
  logic         req_mode;
  logic [W-1:0] counter_in;
  logic         high_in;
  logic         low_in;
  logic [W-1:0] load_val;
  logic         load;
  logic         up;
  logic         down;
  logic         done;
  logic         err;

  modport slave (
    input  req_valid, req_target, req_mode, counter_in, high_in, low_in,
    output req_ready, load_val, load, up, down, done, err
  );

  modport master (
    output req_valid, req_target, req_mode, counter_in, high_in, low_in,
    input  req_ready, load_val, load, up, down, done, err
  );

endinterface

// File: rtl/up_dn_seek_ctrl_step_gap_timer.sv
// Settle-phase down-counter: loaded with the gap on SETTLE entry, expired while it reads zero.
// Latency is gap+1 cycles from start to the last settle cycle; no backpressure.
module step_gap_timer
  import up_dn_ctrl_pkg::*;
#(
  parameter int CW = GAP_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] gap,
  output logic          expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= gap;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/up_dn_seek_ctrl.sv
// Seek/load controller for the up/down counter; done 2+d*(2+STEP_GAP) cycles after handshake, load in 3.
// One request in flight (req_ready only in IDLE); stall abort via UP_DN_SEEK_STALL_CHK_EN.
module up_dn_seek_ctrl
  import up_dn_ctrl_pkg::*;
#(
  parameter int W        = CTR_W_DEF,
  parameter int STEP_GAP = 0
) (
  input logic              clk,
  input logic              rst,
  up_dn_seek_ctrl_if.slave bus
);

  localparam logic [GAP_W-1:0] GAP_CFG = GAP_W'(STEP_GAP);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   target_q;
  logic           mode_q;
  logic           cnt_eq;
  logic           cnt_lt;
  logic           up_ok;
  logic           dn_ok;
  logic           up_s;
  logic           dn_s;
  logic           ld_s;
  logic           hs;
  logic           timer_start;
  logic           gap_expired;
  logic [GAP_W-1:0] gap_val;

  assign hs     = (state == IDLE) && bus.req_valid;
  assign cnt_eq = (bus.counter_in == target_q);
  assign cnt_lt = (bus.counter_in < target_q);
  assign up_ok  = cnt_lt && !bus.high_in;
  assign dn_ok  = !cnt_eq && !cnt_lt && !bus.low_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      mode_q   <= MODE_SEEK;
    end else if (hs) begin
      target_q <= bus.req_target;
      mode_q   <= bus.req_mode;
    end
  end

  // A load settles in exactly one cycle regardless of the configured gap.
  assign gap_val     = (mode_q == MODE_LOAD) ? '0 : GAP_CFG;
  assign timer_start = (state_nxt == SETTLE) && (state != SETTLE);

  step_gap_timer #(
    .CW (GAP_W)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .gap     (gap_val),
    .expired (gap_expired)
  );

`ifdef UP_DN_SEEK_STALL_CHK_EN
  logic [W-1:0] cap_q;
  logic         stall;
  logic         fail_nxt;
  logic         err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else if (up_s || dn_s || ld_s) begin
      cap_q <= bus.counter_in;
    end
  end

  // Seek stalls if the count never moved; load stalls if it never took the target.
  assign stall = (mode_q == MODE_LOAD) ? (bus.counter_in != target_q)
                                       : (bus.counter_in == cap_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state != DONE) begin
      err_q <= fail_nxt;
    end
  end

  assign bus.err = (state == DONE) && err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef UP_DN_SEEK_STALL_CHK_EN
    fail_nxt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt = (bus.req_mode == MODE_LOAD) ? LOAD : STEP;
        end
      end
      LOAD: state_nxt = SETTLE;
      STEP: begin
        if (cnt_eq) begin
          state_nxt = DONE;
        end else if (up_ok || dn_ok) begin
          state_nxt = SETTLE;
        end else begin
          state_nxt = DONE;
`ifdef UP_DN_SEEK_STALL_CHK_EN
          fail_nxt  = 1'b1;
`endif
        end
      end
      SETTLE: begin
        if (gap_expired) begin
`ifdef UP_DN_SEEK_STALL_CHK_EN
          if (stall) begin
            state_nxt = DONE;
            fail_nxt  = 1'b1;
          end else
`endif
          state_nxt = (mode_q == MODE_LOAD) ? DONE : STEP;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_s = (state == LOAD);
    up_s = (state == STEP) && up_ok;
    dn_s = (state == STEP) && dn_ok;
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.load      = ld_s;
  assign bus.up        = up_s;
  assign bus.down      = dn_s;
  assign bus.done      = (state == DONE);
  assign bus.load_val  = target_q;

endmodule

// File: tb/tb_up_dn_seek_ctrl.sv
// Bench: two controllers (STEP_GAP 0 and 2) sharing one request stream, each driving its own counter model.
// Expectations come from distance/gap arithmetic, not from the controller's state machine.
module tb_up_dn_seek_ctrl;
  import up_dn_ctrl_pkg::*;

  localparam int W  = 5;
  localparam int G0 = 0;
  localparam int G1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         req_valid;
  logic [W-1:0] req_target;
  logic         req_mode;
  logic         freeze;
  logic [W-1:0] cnt [2] = '{default: '0};

  logic [1:0]   o_rdy, o_load, o_up, o_dn, o_done, o_err;
  logic [W-1:0] o_lv [2];

  up_dn_seek_ctrl_if #(.W(W)) bus0 ();
  up_dn_seek_ctrl_if #(.W(W)) bus1 ();

  up_dn_seek_ctrl #(.W(W), .STEP_GAP(G0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  up_dn_seek_ctrl #(.W(W), .STEP_GAP(G1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus0.req_valid  = req_valid;
  assign bus0.req_target = req_target;
  assign bus0.req_mode   = req_mode;
  assign bus0.counter_in = cnt[0];
  assign bus0.high_in    = (cnt[0] == 5'd31);
  assign bus0.low_in     = (cnt[0] == 5'd0);
  assign bus1.req_valid  = req_valid;
  assign bus1.req_target = req_target;
  assign bus1.req_mode   = req_mode;
  assign bus1.counter_in = cnt[1];
  assign bus1.high_in    = (cnt[1] == 5'd31);
  assign bus1.low_in     = (cnt[1] == 5'd0);

  assign o_rdy  = {bus1.req_ready, bus0.req_ready};
  assign o_load = {bus1.load, bus0.load};
  assign o_up   = {bus1.up, bus0.up};
  assign o_dn   = {bus1.down, bus0.down};
  assign o_done = {bus1.done, bus0.done};
  assign o_err  = {bus1.err, bus0.err};
  assign o_lv[0] = bus0.load_val;
  assign o_lv[1] = bus1.load_val;

  // Counter model: feedback reflects a strobe one cycle later; freeze models a dead counter.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!freeze) begin
        if (o_load[i])    cnt[i] <= o_lv[i];
        else if (o_up[i]) cnt[i] <= cnt[i] + 5'd1;
        else if (o_dn[i]) cnt[i] <= cnt[i] - 5'd1;
      end
    end
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic handshake(input logic [W-1:0] t, input logic m, input string tag);
    int w = 0;
    while (o_rdy != 2'b11 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("%s.ready_before", tag), int'(o_rdy), 3);
    req_valid  = 1'b1;
    req_target = t;
    req_mode   = m;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] t, input logic m, input string tag);
    int c0 [2];
    int done_at [2], err_at [2], nstrb [2], bad_t [2], bad_dir [2], inv [2], rdy_after [2];
    int d, g, step, exp_strb, exp_done;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      c0[i] = int'(cnt[i]);
      done_at[i] = -1; err_at[i] = -1; nstrb[i] = 0; bad_t[i] = 0;
      bad_dir[i] = 0; inv[i] = 0; rdy_after[i] = -1;
    end
    handshake(t, m, tag);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        g = gap_of(i);
        step = 2 + g;
        if (done_at[i] >= 0 && rdy_after[i] < 0) rdy_after[i] = int'(o_rdy[i]);
        if (done_at[i] < 0) begin
          if (int'(o_load[i]) + int'(o_up[i]) + int'(o_dn[i]) > 1) inv[i]++;
          if (o_up[i] && cnt[i] == 5'd31) inv[i]++;
          if (o_dn[i] && cnt[i] == 5'd0) inv[i]++;
          if (o_load[i] || o_up[i] || o_dn[i]) begin
            if (m == MODE_LOAD) begin
              if (!o_load[i]) bad_dir[i]++;
              if (n != 1) bad_t[i]++;
            end else begin
              if (int'(t) > c0[i] && !o_up[i]) bad_dir[i]++;
              if (int'(t) < c0[i] && !o_dn[i]) bad_dir[i]++;
              if (n != 1 + nstrb[i] * step) bad_t[i]++;
            end
            nstrb[i]++;
          end
          if (o_done[i]) begin
            done_at[i] = n;
            err_at[i]  = int'(o_err[i]);
          end
        end
      end
      if (rdy_after[0] >= 0 && rdy_after[1] >= 0) break;
    end
    for (int i = 0; i < 2; i++) begin
      g = gap_of(i);
      d = (int'(t) > c0[i]) ? int'(t) - c0[i] : c0[i] - int'(t);
      exp_strb = (m == MODE_LOAD) ? 1 : d;
      exp_done = (m == MODE_LOAD) ? 3 : 2 + d * (2 + g);
      check($sformatf("%s.d%0d.done_cycle", tag, i), done_at[i], exp_done);
      check($sformatf("%s.d%0d.err", tag, i), err_at[i], 0);
      check($sformatf("%s.d%0d.strobes", tag, i), nstrb[i], exp_strb);
      check($sformatf("%s.d%0d.strobe_timing", tag, i), bad_t[i], 0);
      check($sformatf("%s.d%0d.strobe_kind", tag, i), bad_dir[i], 0);
      check($sformatf("%s.d%0d.invariants", tag, i), inv[i], 0);
      check($sformatf("%s.d%0d.counter", tag, i), int'(cnt[i]), int'(t));
      check($sformatf("%s.d%0d.load_val", tag, i), int'(o_lv[i]), int'(t));
      check($sformatf("%s.d%0d.ready_after", tag, i), rdy_after[i], 1);
    end
  endtask

  initial begin
    int ups [2], dn_at [2], err_seen [2];
    logic [W-1:0] rt;
    logic rm;
    rst = 1'b1; req_valid = 1'b0; req_target = '0; req_mode = MODE_SEEK; freeze = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.ready", int'(o_rdy), 3);
    check("reset.strobes", int'(o_load | o_up | o_dn), 0);
    check("reset.done_err", int'(o_done | o_err), 0);
    check("reset.load_val", int'(o_lv[0]) + int'(o_lv[1]), 0);
    rst = 1'b0;

    run(5'd3, MODE_LOAD, "load3");
    run(5'd7, MODE_SEEK, "seek3to7");
    run(5'd20, MODE_LOAD, "load20");
    run(5'd17, MODE_SEEK, "seek20to17");
    run(5'd9, MODE_LOAD, "load9");
    run(5'd9, MODE_SEEK, "seek_equal9");
    run(5'd31, MODE_LOAD, "load31");
    run(5'd0, MODE_SEEK, "seek31to0");

    for (int r = 0; r < 6; r++) begin
      rt = W'($urandom_range(0, 31));
      rm = ($urandom_range(0, 3) == 0) ? MODE_LOAD : MODE_SEEK;
      run(rt, rm, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a seek from 5 towards 12.
    run(5'd5, MODE_LOAD, "load5");
    @(negedge clk);
    handshake(5'd12, MODE_SEEK, "midrst");
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst.strobes", int'(o_load | o_up | o_dn), 0);
    check("midrst.done_err", int'(o_done | o_err), 0);
    check("midrst.ready", int'(o_rdy), 3);
    check("midrst.load_val", int'(o_lv[0]) + int'(o_lv[1]), 0);
    dn_at[0] = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (o_done != 2'b00) dn_at[0]++;
    end
    check("midrst.no_done", dn_at[0], 0);
    rst = 1'b0;
    run(5'd5, MODE_LOAD, "after_rst");

    // Dead counter: frozen at 4 while seeking to 6.
    run(5'd4, MODE_LOAD, "load4");
    @(negedge clk);
    freeze = 1'b1;
    handshake(5'd6, MODE_SEEK, "stall");
    for (int i = 0; i < 2; i++) begin
      ups[i] = 0; dn_at[i] = -1; err_seen[i] = 0;
    end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (dn_at[i] < 0) begin
          if (o_up[i]) ups[i]++;
          if (o_err[i]) err_seen[i] = 1;
          if (o_done[i]) dn_at[i] = n;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
`ifdef UP_DN_SEEK_STALL_CHK_EN
      check($sformatf("stall.d%0d.ups", i), ups[i], 1);
      check($sformatf("stall.d%0d.done_cycle", i), dn_at[i], 3 + gap_of(i));
      check($sformatf("stall.d%0d.err", i), err_seen[i], 1);
`else
      check($sformatf("stall.d%0d.ups", i), ups[i], 11 / (2 + gap_of(i)) + 1);
      check($sformatf("stall.d%0d.done_cycle", i), dn_at[i], -1);
      check($sformatf("stall.d%0d.err", i), err_seen[i], 0);
`endif
    end
    rst = 1'b1;
    @(negedge clk);
    freeze = 1'b0;
    rst = 1'b0;
    run(5'd2, MODE_SEEK, "after_stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/up_dn_seek_ctrl.md
# up_dn_seek_ctrl

- Command-side controller for the team's 5-bit up/down counter.
- Accepts a target value over a valid/ready request port and drives the counter's parallel-load value, load, up and down inputs.
- Steps the counter one count at a time until its value matches the target, or loads the target directly.
- Uses the counter's value and high/low flags as feedback; sits between software-facing control logic and the counter instance.

## Interface
- W, 5: counter width; must match the counter instance.
- STEP_GAP, 0: extra idle cycles inserted after each step's settle cycle (rate limit); range 0..15.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle and able to accept.
- req_target  input  W  target count; captured on handshake.
- req_mode  input  1  0 = seek by stepping, 1 = direct load.
- counter_in  input  W  counter's current value.
- high_in  input  1  counter at all-ones.
- low_in  input  1  counter at zero.
- load_val  output  W  parallel-load value to counter; equals captured target.
- load  output  1  one-cycle load strobe.
- up  output  1  one-cycle increment strobe.
- down  output  1  one-cycle decrement strobe.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = stall abort. Constant 0 when stall checking is compiled out.

## Operation
- States: IDLE, LOAD, STEP, SETTLE, DONE.
- Outputs are Moore-decoded from registered state.
- IDLE
  - req_ready=1, all strobes 0.
  - Handshake is req_valid && req_ready: capture target and mode.
  - Then go to LOAD (mode 1) or STEP (mode 0).
- LOAD: load=1 for one cycle -> SETTLE (exactly 1 cycle, STEP_GAP ignored) -> DONE.
- STEP: compare counter_in against target (unsigned).
  - Equal -> DONE, no strobe.
  - counter_in < target and !high_in -> up=1.
  - counter_in > target and !low_in -> down=1.
  - After a strobe -> SETTLE.
  - A strobe blocked by its flag -> DONE with err=1.
- SETTLE: lasts 1+STEP_GAP cycles, then -> STEP.
- DONE: done=1 for one cycle -> IDLE.
- Invariants:
  - load, up, down are mutually exclusive.
  - No more than one strobe per STEP visit.
  - up never asserted while high_in=1; down never asserted while low_in=1.
  - load_val holds the captured target from handshake until the next handshake.
- No wrap-around: stepping never passes 0 or 2^W-1.
- Reset:
  - Asynchronous to IDLE; strobes, done and err drop to 0 immediately.
  - load_val resets to 0; req_ready=1 after reset.
- Reset mid-seek abandons the operation with no done pulse.

## Timing
- Handshake in cycle 0.
- Seek, distance d=|target-counter_in|:
  - STEP visits at cycles 1+k(2+STEP_GAP), k=0..d.
  - done at cycle 2+d(2+STEP_GAP).
  - req_ready again the cycle after done.
- Seek, d=0: done at cycle 2.
- Load mode: load in cycle 1, done in cycle 3.
- Counter feedback is assumed updated one cycle after a strobe; SETTLE covers that cycle.

## Configuration
- Macro: UP_DN_SEEK_STALL_CHK_EN.
- Defined:
  - On each strobe, capture counter_in.
  - On the last SETTLE cycle, if counter_in still equals the captured value (seek) or differs from target (load), go to DONE with err=1.
- Undefined: no capture register, no check; err tied 0; seek relies purely on the compare.

## Structure
- Package up_dn_ctrl_pkg:
  - State enum (IDLE, LOAD, STEP, SETTLE, DONE).
  - MODE_SEEK / MODE_LOAD constants.
  - Default width constant 5.
- Sub-module step_gap_timer:
  - Down-counter loaded with STEP_GAP on entry to SETTLE.
  - Signals expiry to the FSM.

## Test plan
- Seek from 3 to 7, STEP_GAP=0 -> four single-cycle up pulses 2 cycles apart; done at cycle 10; err=0; counter=7.
- Seek from 20 to 17, STEP_GAP=2 -> three down pulses 4 cycles apart; done at cycle 14; up never asserted.
- Target equals current value (9) -> no strobes; done at cycle 2; req_ready high at cycle 3.
- Load mode, target 31 -> load=1 with load_val=31 at cycle 1; done at cycle 3; then seek to 0 -> 31 downs, and down never asserted while low_in=1.
- rst asserted during SETTLE of a seek (5->12) -> outputs 0 at once, no done, req_ready=1; a new request is accepted after rst falls.
- With UP_DN_SEEK_STALL_CHK_EN defined, counter model frozen at 4, target 6 -> one up pulse, then done with err=1 at cycle 3. Without the macro -> up pulses repeat every 2 cycles and err stays 0.
